scan_addr_gen: RTL and testbench

//  Parametrised read/write address generator for windowed image kernels (Sobel and others).

---
 rtl/scan_addr_gen.sv | 179 +++++++++++++++++
 tb/tb_scan_addr_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: read/write address generator for windowed image kernels.
// It visits every interior pixel of a width x height frame. A margin of
// BORDER pixels on each edge is skipped. The scan order is raster or
// serpentine, and each step waits for a valid/ready handshake.
// Optional feature macro SCAN_STATS_EN: when it is defined, step_count
// counts accepted steps. It clears on load and saturates at all-ones.
// When it is undefined, step_count is tied to 0.
module scan_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 12,
    parameter int BORDER = 1
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 load,
    input  logic [ADDR_W-1:0]    base_addr_r,
    input  logic [ADDR_W-1:0]    base_addr_w,
    input  logic [DIM_W-1:0]     width,
    input  logic [DIM_W-1:0]     height,
    input  logic                 mode,
    output logic                 pos_valid,
    input  logic                 pos_ready,
    output logic [ADDR_W-1:0]    addr_r,
    output logic [ADDR_W-1:0]    addr_w,
    output logic [DIM_W-1:0]     x,
    output logic [DIM_W-1:0]     y,
    output logic [1:0]           direction,
    output logic                 load_done,
    output logic                 all_done,
    output logic [2*DIM_W-1:0]   step_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0]        DIR_NONE  = 2'b00;
    localparam logic [1:0]        DIR_RIGHT = 2'b01;
    localparam logic [1:0]        DIR_LEFT  = 2'b10;
    localparam logic [1:0]        DIR_ROW   = 2'b11;
    localparam logic [DIM_W-1:0]  B_D       = DIM_W'(BORDER);
    localparam logic [DIM_W-1:0]  B_P1      = DIM_W'(BORDER + 1);
    localparam logic [DIM_W:0]    MIN_DIM   = (DIM_W+1)'(2*BORDER + 1);
    // From the last interior column of one row to the first of the next.
    localparam logic [ADDR_W-1:0] ROW_SKIP  = ADDR_W'(2*BORDER + 1);

    state_t              state_q, state_d;
    logic [DIM_W-1:0]    x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0]   ar_q, ar_d, aw_q, aw_d;
    logic [DIM_W-1:0]    width_q, width_d, height_q, height_d;
    logic                mode_q, mode_d;
    logic                left_q, left_d;      // serpentine: moving left on this row
    logic                load_done_q, load_done_d;

    logic [DIM_W-1:0]    xmin, xmax, ymax;
    logic [ADDR_W-1:0]   start_off;
    logic                too_small, row_end, accept;
    logic [1:0]          dir;

    assign xmin      = B_D;
    assign xmax      = width_q - B_P1;
    assign ymax      = height_q - B_P1;
    assign start_off = ADDR_W'(BORDER) * ADDR_W'(width) + ADDR_W'(BORDER);
    assign too_small = ({1'b0, width} < MIN_DIM) || ({1'b0, height} < MIN_DIM);
    assign accept    = (state_q == RUN) && pos_ready;
    assign row_end   = (mode_q && left_q) ? (x_q == xmin) : (x_q == xmax);

    // Decide the move that the next accept will apply to the current pixel.
    always_comb begin
        dir = DIR_NONE;
        if (state_q == RUN) begin
            if (row_end)     dir = (y_q == ymax) ? DIR_NONE : DIR_ROW;
            else if (left_q) dir = DIR_LEFT;
            else             dir = DIR_RIGHT;
        end
    end

    // Next state: a load overrides a handshake; otherwise an accept advances one pixel.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        ar_d        = ar_q;
        aw_d        = aw_q;
        width_d     = width_q;
        height_d    = height_q;
        mode_d      = mode_q;
        left_d      = left_q;
        load_done_d = 1'b0;
        if (load) begin
            width_d     = width;
            height_d    = height;
            mode_d      = mode;
            left_d      = 1'b0;
            x_d         = B_D;
            y_d         = B_D;
            ar_d        = base_addr_r + start_off;
            aw_d        = base_addr_w + start_off;
            load_done_d = 1'b1;
            state_d     = too_small ? DONE : RUN;
        end else if (accept) begin
            case (dir)
                DIR_RIGHT: begin
                    x_d  = x_q + 1'b1;
                    ar_d = ar_q + 1'b1;
                    aw_d = aw_q + 1'b1;
                end
                DIR_LEFT: begin
                    x_d  = x_q - 1'b1;
                    ar_d = ar_q - 1'b1;
                    aw_d = aw_q - 1'b1;
                end
                DIR_ROW: begin
                    y_d = y_q + 1'b1;
                    if (mode_q) begin
                        ar_d   = ar_q + ADDR_W'(width_q);
                        aw_d   = aw_q + ADDR_W'(width_q);
                        left_d = ~left_q;
                    end else begin
                        x_d  = xmin;
                        ar_d = ar_q + ROW_SKIP;
                        aw_d = aw_q + ROW_SKIP;
                    end
                end
                default: state_d = DONE;   // last pixel accepted; position holds
            endcase
        end
    end

    // State and position registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            ar_q        <= '0;
            aw_q        <= '0;
            width_q     <= '0;
            height_q    <= '0;
            mode_q      <= 1'b0;
            left_q      <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            ar_q        <= ar_d;
            aw_q        <= aw_d;
            width_q     <= width_d;
            height_q    <= height_d;
            mode_q      <= mode_d;
            left_q      <= left_d;
            load_done_q <= load_done_d;
        end
    end

`ifdef SCAN_STATS_EN
    logic [2*DIM_W-1:0] cnt_q;

    // Accepted-step counter: it clears on load and saturates.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)                 cnt_q <= '0;
        else if (load)                cnt_q <= '0;
        else if (accept && ~&cnt_q)   cnt_q <= cnt_q + 1'b1;
    end

    assign step_count = cnt_q;
`else
    assign step_count = '0;
`endif

    assign pos_valid = (state_q == RUN);
    assign all_done  = (state_q == DONE);
    assign addr_r    = ar_q;
    assign addr_w    = aw_q;
    assign x         = x_q;
    assign y         = y_q;
    assign direction = dir;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_scan_addr_gen.sv
// Scoreboard bench for scan_addr_gen. On each load, a reference model lists
// every interior pixel in scan order, computing addresses as base + y*width + x.
// The model pushes these entries into a queue. A monitor pops one entry per
// accepted handshake and compares it with the DUT outputs.
module tb_scan_addr_gen;
    localparam int ADDR_W = 16;
    localparam int DIM_W  = 12;
    localparam int BORDER = 1;

    logic              clk = 1'b0;
    logic              n_reset = 1'b1;
    logic              load = 1'b0;
    logic [ADDR_W-1:0] base_r = '0, base_w = '0;
    logic [DIM_W-1:0]  width = '0, height = '0;
    logic              mode = 1'b0;
    logic              pos_ready = 1'b0;
    logic              pos_valid, load_done, all_done;
    logic [ADDR_W-1:0] addr_r, addr_w;
    logic [DIM_W-1:0]  x, y;
    logic [1:0]        direction;
    logic [2*DIM_W-1:0] step_count;

    scan_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .BORDER(BORDER)) dut (
        .clk(clk), .n_reset(n_reset), .load(load),
        .base_addr_r(base_r), .base_addr_w(base_w),
        .width(width), .height(height), .mode(mode),
        .pos_valid(pos_valid), .pos_ready(pos_ready),
        .addr_r(addr_r), .addr_w(addr_w), .x(x), .y(y),
        .direction(direction), .load_done(load_done), .all_done(all_done),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] ar;
        logic [ADDR_W-1:0] aw;
        logic [DIM_W-1:0]  x;
        logic [DIM_W-1:0]  y;
        logic [1:0]        dir;
    } exp_t;

    exp_t expq[$];
    exp_t last_exp;
    int   checks = 0, failures = 0;
    int   acc_cnt = 0, exp_total = 0;
    int   rdy_mode = 0;          // 0: ready held high, 1: random gaps, 2: held low

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: list the interior pixels in visiting order.
    task automatic build_expected(input int br, input int bw, input int w, input int h, input bit m);
        int nx, ny, xx, yy;
        exp_t e;
        expq.delete();
        exp_total = 0;
        if (w < 2*BORDER+1 || h < 2*BORDER+1) return;
        nx = w - 2*BORDER;
        ny = h - 2*BORDER;
        for (int r = 0; r < ny; r++) begin
            for (int k = 0; k < nx; k++) begin
                xx = (m && (r % 2 == 1)) ? (w - 1 - BORDER - k) : (BORDER + k);
                yy = BORDER + r;
                e.ar = ADDR_W'(br + yy*w + xx);
                e.aw = ADDR_W'(bw + yy*w + xx);
                e.x  = DIM_W'(xx);
                e.y  = DIM_W'(yy);
                if (k == nx-1) e.dir = (r == ny-1) ? 2'b00 : 2'b11;
                else           e.dir = (m && (r % 2 == 1)) ? 2'b10 : 2'b01;
                expq.push_back(e);
            end
        end
        exp_total = nx * ny;
    endtask

    // Ready driver: changes just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       pos_ready = 1'b1;
            1:       pos_ready = ($urandom_range(0, 2) != 0);
            default: pos_ready = 1'b0;
        endcase
    end

    // Monitor: scoreboard pops, load_done pulse and hold-while-stalled checks.
    logic              prev_load = 1'b0;
    logic              hold_pend = 1'b0;
    logic [ADDR_W-1:0] h_ar, h_aw;
    logic [DIM_W-1:0]  h_x, h_y;
    logic [1:0]        h_dir;
    always @(negedge clk) begin
        if (!n_reset) begin
            prev_load = 1'b0;
            hold_pend = 1'b0;
        end else begin
            chk("load_done", load_done, prev_load);
            if (hold_pend && pos_valid) begin
                chk("hold_addr_r", addr_r, h_ar);
                chk("hold_addr_w", addr_w, h_aw);
                chk("hold_xy", {x, y}, {h_x, h_y});
                chk("hold_dir", direction, h_dir);
            end
            hold_pend = pos_valid && !pos_ready && !load;
            h_ar = addr_r; h_aw = addr_w; h_x = x; h_y = y; h_dir = direction;
            if (pos_valid && pos_ready && !load) begin
                if (expq.size() == 0) begin
                    chk("unexpected_accept", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("addr_r", addr_r, e.ar);
                    chk("addr_w", addr_w, e.aw);
                    chk("x", x, e.x);
                    chk("y", y, e.y);
                    chk("direction", direction, e.dir);
                    last_exp = e;
                    acc_cnt++;
                end
            end
            prev_load = load;
        end
    end

    task automatic do_load(input int br, input int bw, input int w, input int h, input bit m);
        @(posedge clk); #1;
        base_r = ADDR_W'(br); base_w = ADDR_W'(bw);
        width = DIM_W'(w); height = DIM_W'(h); mode = m;
        load = 1'b1;
        build_expected(br, bw, w, h, m);
        acc_cnt = 0;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!all_done && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_all_done"}, all_done, 1);
        @(negedge clk); #1;
        chk({name, "_valid_low"}, pos_valid, 0);
        chk({name, "_queue_empty"}, expq.size(), 0);
        chk({name, "_accepts"}, acc_cnt, exp_total);
        chk({name, "_dir_done"}, direction, 2'b00);
        if (exp_total > 0) begin
            chk({name, "_last_addr_r"}, addr_r, last_exp.ar);
            chk({name, "_last_addr_w"}, addr_w, last_exp.aw);
            chk({name, "_last_xy"}, {x, y}, {last_exp.x, last_exp.y});
        end
`ifdef SCAN_STATS_EN
        chk({name, "_step_count"}, step_count, exp_total);
`else
        chk({name, "_step_count"}, step_count, 0);
`endif
    endtask

    initial begin
        // Reset state.
        #2 n_reset = 1'b0;
        #1;
        chk("rst_outputs", {pos_valid, load_done, all_done, direction}, 0);
        chk("rst_addr", {addr_r, addr_w, x, y}, 0);
        chk("rst_step_count", step_count, 0);
        repeat (2) @(posedge clk);
        #2 n_reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_no_valid", {pos_valid, all_done}, 0);

        // Serpentine 8x6 with ready held high. Also check the first position right after load.
        rdy_mode = 0;
        do_load(32'h100, 32'h400, 8, 6, 1'b1);
        @(negedge clk);
        chk("t1_first_addr_r", addr_r, 16'h109);
        chk("t1_first_addr_w", addr_w, 16'h409);
        chk("t1_first_dir", direction, 2'b01);
        wait_done("serp");

        // Raster, same frame.
        do_load(32'h100, 32'h400, 8, 6, 1'b0);
        wait_done("raster");

        // Serpentine with random ready gaps.
        rdy_mode = 1;
        do_load(32'h100, 32'h400, 8, 6, 1'b1);
        wait_done("serp_gaps");

        // Reload in the middle of a scan.
        rdy_mode = 0;
        do_load(32'h100, 32'h400, 8, 6, 1'b1);
        for (int n = 0; n < 100 && acc_cnt < 10; n++) @(negedge clk);
        do_load(32'h200, 32'h800, 5, 3, 1'b0);
        wait_done("reload");

        // Frame too narrow: DONE at once, never valid.
        do_load(32'h200, 32'h800, 2, 6, 1'b1);
        @(negedge clk);
        chk("narrow_done", all_done, 1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("narrow_no_valid", pos_valid, 0);
        end
        chk("narrow_accepts", acc_cnt, 0);

        // Random frames, bases near wrap, both modes, random ready.
        for (int i = 0; i < 16; i++) begin
            rdy_mode = $urandom_range(0, 1);
            do_load((i % 3 == 0) ? 32'hFFF0 + $urandom_range(0, 15) : $urandom_range(0, 16'hFFFF),
                    $urandom_range(0, 16'hFFFF),
                    $urandom_range(1, 11), $urandom_range(1, 9), 1'($urandom_range(0, 1)));
            wait_done("random");
        end

        // Asynchronous reset mid-scan.
        rdy_mode = 0;
        do_load(32'h100, 32'h400, 8, 6, 1'b1);
        repeat (6) @(posedge clk);
        #3 n_reset = 1'b0;
        #1;
        chk("async_rst_outputs", {pos_valid, load_done, all_done, direction}, 0);
        chk("async_rst_addr", {addr_r, addr_w, x, y}, 0);
        chk("async_rst_step_count", step_count, 0);
        expq.delete();
        acc_cnt = 0;
        repeat (2) @(posedge clk);
        #3 n_reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {pos_valid, all_done}, 0);
        chk("post_rst_accepts", acc_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit as a safety net.
    initial begin
        #900000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
